prbs_burst_ctrl: RTL
====================

Name: prbs_burst_ctrl

Overview:
- Sequencer for the byte-wide PRBS15 generator (polynomial x^15+x^14+1).
- Each burst is:
  1. a framing preamble: a 32-bit pattern word, sent as bytes and repeated n times;
  2. then PRBS_LEN pseudo-random bytes.
- The burst goes out on a valid/ready byte stream.
- A host/CSR block drives it through a start/busy/done handshake. It sits between that block and the serializer/TX lane.

Parameters:
- SEED, 15'h0011, LFSR seed used when cfg_seed is zero (all-zero is the lock-up state).
- LEN_W, 16, width of the PRBS byte counter.

Ports:
- CLK  input  1  clock.
- RST  input  1  synchronous reset, active-high.
- start  input  1  begin burst; sampled only in IDLE.
- abort  input  1  terminate burst; return to IDLE.
- cfg_pattern  input  32  preamble word, sent MSB byte first.
- cfg_repeat  input  8  number of preamble words (n); 0 = no preamble.
- cfg_prbs_len  input  LEN_W  number of PRBS bytes; 0 = no PRBS phase.
- cfg_seed  input  15  LFSR seed; 0 means use SEED.
- busy  output  1  high whenever state != IDLE.
- done  output  1  one-cycle pulse at burst completion.
- out_data  output  8  stream byte.
- out_valid  output  1  byte valid.
- out_ready  input  1  downstream accept.

Behaviour:
- Reset (RST high at a CLK edge):
  - state=IDLE; busy=0, done=0, out_valid=0, out_data=0.
  - LFSR=SEED; all counters 0.
  - RST overrides start and abort.
- FSM states: IDLE, PATTERN, PRBS, DONE.
- Starting a burst (IDLE, start=1 at edge t):
  - Latch cfg_*.
  - Load LFSR with cfg_seed, or SEED if cfg_seed==0.
  - Clear byte_idx (2b), rep_cnt (8b) and prbs_cnt (LEN_W).
  - Next state:
    - cfg_repeat!=0 → PATTERN.
    - else cfg_prbs_len!=0 → PRBS.
    - else → DONE.
  - In PATTERN or PRBS, the first byte is presented with out_valid=1 at t+1.
- Handshake (AXI-stream rules):
  - A byte transfers on any edge with out_valid & out_ready.
  - While out_valid & !out_ready, out_data is held stable.
  - The next byte is presented the cycle after a transfer, with no bubble, so a sustained ready gives 1 byte/cycle.
- PATTERN state:
  - Byte k = cfg_pattern[31-8k -: 8] for k=0..3.
  - On each transfer, byte_idx++. When byte_idx wraps 3→0, rep_cnt++.
  - On the transfer of byte 3 with rep_cnt==cfg_repeat-1, leave for PRBS, or DONE if cfg_prbs_len==0.
- PRBS state:
  - Each byte = LFSR state after 8 single-bit shifts, taken as LFSR[7:0].
  - Shift rule: LFSR <= {LFSR[13:0], LFSR[14]^LFSR[13]}. The first generated bit lands in out_data[7].
  - The LFSR advances 8 bits only on a transfer; the next byte is precomputed combinationally.
  - After the transfer with prbs_cnt==cfg_prbs_len-1 → DONE.
- DONE state: one cycle; done=1, out_valid=0, busy=1; then → IDLE.
  - done is therefore high at t+1 after the final transfer at edge t.
- abort:
  - In any non-IDLE state, abort=1 at an edge → IDLE next cycle, out_valid=0, no done pulse.
  - abort wins over a simultaneous transfer; that byte counts as sent downstream, but the burst ends.
- start while busy is ignored, as is abort in IDLE.
- Config inputs may change freely during a burst; only the latched copies are used.
- cfg_repeat=255 must produce exactly 1020 preamble bytes (no counter overflow).
- cfg_prbs_len is full-range (up to 2^LEN_W-1).

Decomposition:
- Package prbs_pkg holds:
  - typedef enum logic [1:0] {IDLE, PATTERN, PRBS, DONE} prbs_state_e;
  - localparam PRBS_ORDER=15, TAP_A=14, TAP_B=13;
  - a function prbs15_step8(logic [14:0]) returning the LFSR state after 8 shifts.
- Sub-module prbs15_byte_gen:
  - Holds the LFSR register with load/seed and advance inputs, and the byte output.
  - It is instantiated by the controller.
  - prbs_burst_ctrl owns the FSM, the counters and the output register.

Test Plan:
- Reset, then start with cfg_repeat=1, cfg_pattern=32'hA5C3_0F1E, cfg_prbs_len=0, out_ready=1:
  - Bytes A5, C3, 0F, 1E on consecutive cycles starting at t+1.
  - done pulses once, 1 cycle after the last transfer; busy then falls.
- start with cfg_repeat=0, cfg_seed=0, cfg_prbs_len=2, ready=1:
  - PRBS bytes 8'h00 then 8'h66 from SEED 15'h0011; done follows.
- cfg_repeat=2, cfg_prbs_len=3, out_ready toggling 1-0-0-1 pseudo-randomly:
  - 8 pattern bytes, then 3 PRBS bytes.
  - out_data stable whenever valid & !ready; byte count exact; stream matches the C model.
- cfg_repeat=255, cfg_prbs_len=16'hFFFF, ready=1:
  - 1020 pattern bytes then 65535 PRBS bytes.
  - A PRBS byte sequence checked against the model confirms wrap-free counting; exactly one done.
- abort mid-PRBS (after 5 bytes) while out_ready=1:
  - IDLE the next cycle, out_valid=0, no done.
  - A new start then restarts from the seed: first byte 8'h00 for seed 0.
- RST asserted mid-PATTERN:
  - All outputs 0 the next cycle.
  - start asserted during busy before the RST is ignored (no second burst).

Source files
------------

// File: rtl/prbs_pkg.sv
// Shared definitions for the PRBS15 burst sequencer.
//   prbs_state_e : controller FSM states
//   PRBS_ORDER   : LFSR length (x^15 + x^14 + 1)
//   TAP_A/TAP_B  : feedback taps, new bit = lfsr[TAP_A] ^ lfsr[TAP_B]
//   prbs15_step8 : LFSR state after eight single-bit shifts
package prbs_pkg;

  typedef enum logic [1:0] {
    IDLE,
    PATTERN,
    PRBS,
    DONE
  } prbs_state_e;

  localparam int PRBS_ORDER = 15;
  localparam int TAP_A      = 14;
  localparam int TAP_B      = 13;

  // Eight left shifts; the first generated bit ends up in bit 7, so the
  // low byte of the result is the output byte MSB-first.
  function automatic logic [PRBS_ORDER-1:0] prbs15_step8(input logic [PRBS_ORDER-1:0] state);
    logic [PRBS_ORDER-1:0] s;
    s = state;
    for (int i = 0; i < 8; i++) begin
      s = {s[PRBS_ORDER-2:0], s[TAP_A] ^ s[TAP_B]};
    end
    return s;
  endfunction

endpackage

// File: rtl/prbs15_byte_gen.sv
// Byte-wide PRBS15 generator.
//   CLK, RST : clock, synchronous active-high reset (LFSR returns to SEED)
//   load     : load the LFSR with seed (has priority over advance)
//   seed     : value loaded on load
//   advance  : step the LFSR by eight bits (one byte consumed)
//   byte_o   : byte produced by the next eight shifts of the current state
module prbs15_byte_gen
  import prbs_pkg::*;
#(
  parameter logic [14:0] SEED = 15'h0011
) (
  input  logic        CLK,
  input  logic        RST,
  input  logic        load,
  input  logic [14:0] seed,
  input  logic        advance,
  output logic [7:0]  byte_o
);

  logic [PRBS_ORDER-1:0] lfsr_q;
  logic [PRBS_ORDER-1:0] lfsr_d;
  logic [PRBS_ORDER-1:0] step_s;

  // The byte is computed ahead from the current state, so it is on the
  // bus immediately and the register only moves when that byte is taken.
  assign step_s = prbs15_step8(lfsr_q);
  assign byte_o = step_s[7:0];

  always_comb begin
    lfsr_d = lfsr_q;
    if (load) begin
      lfsr_d = seed;
    end else if (advance) begin
      lfsr_d = step_s;
    end
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      lfsr_q <= SEED;
    end else begin
      lfsr_q <= lfsr_d;
    end
  end

endmodule

// File: rtl/prbs_burst_ctrl.sv
// Burst sequencer: preamble words followed by PRBS15 bytes on a
// valid/ready byte stream, controlled by a start/busy/done handshake.
//   CLK, RST         : clock, synchronous active-high reset
//   start, abort     : begin a burst (IDLE only) / end it without done
//   cfg_pattern      : preamble word, MSB byte first
//   cfg_repeat       : number of preamble words (0 = none)
//   cfg_prbs_len     : number of PRBS bytes (0 = none)
//   cfg_seed         : LFSR seed, 0 selects SEED
//   busy, done       : burst active / one-cycle completion pulse
//   out_data, out_valid, out_ready : byte stream
module prbs_burst_ctrl
  import prbs_pkg::*;
#(
  parameter logic [14:0] SEED  = 15'h0011,
  parameter int          LEN_W = 16
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             start,
  input  logic             abort,
  input  logic [31:0]      cfg_pattern,
  input  logic [7:0]       cfg_repeat,
  input  logic [LEN_W-1:0] cfg_prbs_len,
  input  logic [14:0]      cfg_seed,
  output logic             busy,
  output logic             done,
  output logic [7:0]       out_data,
  output logic             out_valid,
  input  logic             out_ready
);

  prbs_state_e      state_q, state_d;
  logic [31:0]      pattern_q, pattern_d;
  logic [7:0]       repeat_q, repeat_d;
  logic [LEN_W-1:0] prbs_len_q, prbs_len_d;
  logic [1:0]       byte_idx_q, byte_idx_d;
  logic [7:0]       rep_cnt_q, rep_cnt_d;
  logic [LEN_W-1:0] prbs_cnt_q, prbs_cnt_d;
  logic             out_valid_q, out_valid_d;
  logic             done_q, done_d;

  logic             xfer;
  logic             gen_load;
  logic             gen_advance;
  logic [14:0]      gen_seed;
  logic [7:0]       prbs_byte;
  logic [7:0]       pattern_byte;

  prbs15_byte_gen #(.SEED(SEED)) u_gen (
    .CLK     (CLK),
    .RST     (RST),
    .load    (gen_load),
    .seed    (gen_seed),
    .advance (gen_advance),
    .byte_o  (prbs_byte)
  );

  assign xfer = out_valid_q & out_ready;

  always_comb begin
    unique case (byte_idx_q)
      2'd0: pattern_byte = pattern_q[31:24];
      2'd1: pattern_byte = pattern_q[23:16];
      2'd2: pattern_byte = pattern_q[15:8];
      2'd3: pattern_byte = pattern_q[7:0];
    endcase
  end

  // NOTE: every signal gets a default before the case so no path leaves it
  // unassigned; a missing default here infers a latch.
  always_comb begin
    state_d     = state_q;
    pattern_d   = pattern_q;
    repeat_d    = repeat_q;
    prbs_len_d  = prbs_len_q;
    byte_idx_d  = byte_idx_q;
    rep_cnt_d   = rep_cnt_q;
    prbs_cnt_d  = prbs_cnt_q;
    out_valid_d = out_valid_q;
    done_d      = 1'b0;
    gen_load    = 1'b0;
    gen_advance = 1'b0;
    gen_seed    = (cfg_seed != '0) ? cfg_seed : SEED;

    if (state_q != IDLE && abort) begin
      // Abort beats a simultaneous transfer and suppresses done.
      state_d     = IDLE;
      out_valid_d = 1'b0;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (start) begin
            pattern_d  = cfg_pattern;
            repeat_d   = cfg_repeat;
            prbs_len_d = cfg_prbs_len;
            byte_idx_d = '0;
            rep_cnt_d  = '0;
            prbs_cnt_d = '0;
            gen_load   = 1'b1;
            if (cfg_repeat != '0) begin
              state_d     = PATTERN;
              out_valid_d = 1'b1;
            end else if (cfg_prbs_len != '0) begin
              state_d     = PRBS;
              out_valid_d = 1'b1;
            end else begin
              state_d = DONE;
              done_d  = 1'b1;
            end
          end
        end
        PATTERN: begin
          if (xfer) begin
            byte_idx_d = byte_idx_q + 2'd1;
            if (byte_idx_q == 2'd3) begin
              rep_cnt_d = rep_cnt_q + 8'd1;
              // Compare against repeat-1 so 255 words never needs a 9th bit.
              if (rep_cnt_q == repeat_q - 8'd1) begin
                if (prbs_len_q != '0) begin
                  state_d = PRBS;
                end else begin
                  state_d     = DONE;
                  out_valid_d = 1'b0;
                  done_d      = 1'b1;
                end
              end
            end
          end
        end
        PRBS: begin
          if (xfer) begin
            gen_advance = 1'b1;
            prbs_cnt_d  = prbs_cnt_q + LEN_W'(1);
            if (prbs_cnt_q == prbs_len_q - LEN_W'(1)) begin
              state_d     = DONE;
              out_valid_d = 1'b0;
              done_d      = 1'b1;
            end
          end
        end
        DONE: begin
          state_d = IDLE;
        end
      endcase
    end
  end

  // NOTE: sequential state is updated with non-blocking assignments so all
  // flops see the pre-edge values regardless of statement order.
  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q     <= IDLE;
      pattern_q   <= '0;
      repeat_q    <= '0;
      prbs_len_q  <= '0;
      byte_idx_q  <= '0;
      rep_cnt_q   <= '0;
      prbs_cnt_q  <= '0;
      out_valid_q <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      pattern_q   <= pattern_d;
      repeat_q    <= repeat_d;
      prbs_len_q  <= prbs_len_d;
      byte_idx_q  <= byte_idx_d;
      rep_cnt_q   <= rep_cnt_d;
      prbs_cnt_q  <= prbs_cnt_d;
      out_valid_q <= out_valid_d;
      done_q      <= done_d;
    end
  end

  assign busy      = (state_q != IDLE);
  assign done      = done_q;
  assign out_valid = out_valid_q;
  // Only registered values feed this mux; it is zero whenever no byte is valid.
  assign out_data  = (state_q == PATTERN) ? pattern_byte :
                     (state_q == PRBS)    ? prbs_byte    : 8'h00;

endmodule
